histogram_median_finder: RTL
============================

// Module: histogram_median_finder
// PURPOSE
//  Read-side consumer of the x/y projection-histogram block. On start it issues a read request and captures the
//  serial x and y bin streams into local buffers. It then scans the buffers and reports the median column and
//  median row of active pixels, which are the object centre used by the downstream filter logic.
// PARAMETERS
//  IMWIDTH   240  number of x bins (max stored x samples)
//  IMHEIGHT  180  number of y bins (max stored y samples)
//  BINW      8    bin value width; totals are 16 bits (240*255=61200 fits)
// PORTS
//  clk            in   1     system clock
//  reset          in   1     synchronous, active-high reset
//  start          in   1     1-cycle request to compute medians; ignored while busy=1
//  histReady      in   1     histogram block idle/ready flag
//  readHistogram  out  1     1-cycle read command to histogram block
//  xHistogramIn   in   BINW  x bin value, qualified by xValid
//  xValid         in   1     x sample valid
//  yHistogramIn   in   BINW  y bin value, qualified by yValid
//  yValid         in   1     y sample valid
//  busy           out  1     high from accepted start until done
//  done           out  1     1-cycle pulse, results valid
//  xMedian        out  8     median x bin index
//  yMedian        out  8     median y bin index
//  xTotal         out  16    sum of received x bins
//  yTotal         out  16    sum of received y bins
//  empty          out  1     xTotal==0 or yTotal==0 (medians forced to 0)
// BEHAVIOUR
//  Reset: state IDLE; readHistogram=0, busy=0, done=0, xMedian=yMedian=0, xTotal=yTotal=0, empty=0.
//  FSM IDLE -> REQ -> HOLD -> COLLECT -> SCAN -> IDLE.
//  IDLE: start=1 -> REQ, busy=1. Zero sample counters and running totals.
//  REQ: wait until histReady=1, then assert readHistogram for exactly one cycle and go to HOLD.
//  HOLD: 2 cycles with histReady ignored, covering its latency before falling; then COLLECT.
//  COLLECT: each cycle with xValid=1, store xHistogramIn at xBuf[xCnt], xCnt++, xTotal+=value.
//   The same applies to y with yValid. x and y are independent and may be valid on the same cycle.
//   Samples with xCnt==IMWIDTH (or yCnt==IMHEIGHT) are dropped; counters saturate.
//   Exit to SCAN on the first cycle with histReady=1. A sample valid on that cycle is still captured.
//  SCAN: index k=0..max(IMWIDTH,IMHEIGHT)-1, one bin per cycle for both axes in parallel.
//   Bin value = xBuf[k] if k<xCnt, else 0. Unwritten or stale buffer entries are never used.
//   Running cumulative sum cx (17b). xMedian = first k where 2*cx >= xTotal. Latch it once; later k ignored.
//   y is handled identically against yTotal and IMHEIGHT.
//   After the last index: done=1 for 1 cycle, busy=0, outputs updated together, return to IDLE.
//  Outputs hold their values until the next done. empty=1 -> the corresponding median = 0.
//  Latency start->done: wait-for-ready + 1 + 2 + collect length + max(IMWIDTH,IMHEIGHT) + 1 cycles.
//  Totals never overflow within limits. Bin values are unsigned; no saturation is needed.
//  start during busy: ignored, with no queuing. start and reset together: reset wins.
//  Reset mid-operation: abort immediately to IDLE. readHistogram is deasserted in the same cycle.
//  Outputs return to reset values.
// TESTING
//  1. Single pixel x=10,y=5, 1 at each bin -> xTotal=1, yTotal=1, xMedian=10, yMedian=5, done once.
//  2. x bins 0..3 = 1,1,1,1 (total 4) -> xMedian=1, since 2*cum first >= 4 at k=1; y bins all 0 -> empty=1.
//  3. Uniform x bins =1 over 239 samples -> xTotal=239, xMedian=119; samples beyond IMWIDTH are dropped.
//  4. histReady held 0 for 20 cycles after start -> readHistogram pulses only once histReady=1, exactly 1 cycle.
//  5. start pulsed again while busy -> no second readHistogram; results equal the single-run values.
//  6. reset asserted mid-COLLECT -> next cycle busy=0, outputs 0; a fresh start gives correct medians.

Source files
------------

// File: rtl/histogram_median_finder_if.sv
// Handshake and data bundle between the median finder and its requester/histogram source.
interface histogram_median_finder_if #(
    parameter int BINW = 8
);
    logic            start;
    logic            histReady;
    logic            readHistogram;
    logic [BINW-1:0] xHistogramIn;
    logic            xValid;
    logic [BINW-1:0] yHistogramIn;
    logic            yValid;
    logic            busy;
    logic            done;
    logic [7:0]      xMedian;
    logic [7:0]      yMedian;
    logic [15:0]     xTotal;
    logic [15:0]     yTotal;
    logic            empty;

    modport master (
        output start, histReady, xHistogramIn, xValid, yHistogramIn, yValid,
        input  readHistogram, busy, done, xMedian, yMedian, xTotal, yTotal, empty
    );

    modport slave (
        input  start, histReady, xHistogramIn, xValid, yHistogramIn, yValid,
        output readHistogram, busy, done, xMedian, yMedian, xTotal, yTotal, empty
    );
endinterface

// File: rtl/histogram_median_finder.sv
// Captures x/y projection histograms from the histogram block and reports the
// median column/row (object centre) plus the per-axis pixel totals.
module histogram_median_finder #(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180,
    parameter int BINW     = 8
) (
    input  logic clk,
    input  logic reset,
    histogram_median_finder_if.slave hif
);
    localparam int MAXN = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
    localparam int CW   = $clog2(MAXN + 1);
    localparam logic [CW-1:0] XLIM  = CW'(IMWIDTH);
    localparam logic [CW-1:0] YLIM  = CW'(IMHEIGHT);
    localparam logic [CW-1:0] LASTK = CW'(MAXN - 1);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, COLLECT, SCAN} state_t;

    state_t          state, stateNext;
    logic            holdCnt;
    logic            readHist;
    logic [CW-1:0]   xCnt, yCnt, k;
    logic [15:0]     xAcc, yAcc;
    logic [16:0]     cx, cy, cxNext, cyNext;
    logic            xFound, yFound, xHit, yHit;
    logic [CW-1:0]   xMedReg, yMedReg, xMedNext, yMedNext;
    logic [BINW-1:0] xBin, yBin;
    logic            xTake, yTake;

    logic [BINW-1:0] xBuf [IMWIDTH];
    logic [BINW-1:0] yBuf [IMHEIGHT];

    always_comb begin
        stateNext = state;
        readHist  = 1'b0;
        case (state)
            IDLE:    if (hif.start) stateNext = REQ;
            REQ:     if (hif.histReady) begin
                         readHist  = 1'b1;
                         stateNext = HOLD;
                     end
            HOLD:    if (holdCnt) stateNext = COLLECT;
            COLLECT: if (hif.histReady) stateNext = SCAN;
            SCAN:    if (k == LASTK) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Combinational so the read strobe drops in the very cycle reset is raised.
    assign hif.readHistogram = readHist && !reset;
    assign hif.busy          = (state != IDLE);

    assign xTake = (state == COLLECT) && hif.xValid && (xCnt < XLIM);
    assign yTake = (state == COLLECT) && hif.yValid && (yCnt < YLIM);

    // Entries at or beyond the received count read as zero, so stale data never leaks in.
    always_comb begin
        xBin     = (k < xCnt) ? xBuf[k] : '0;
        yBin     = (k < yCnt) ? yBuf[k] : '0;
        cxNext   = cx + 17'(xBin);
        cyNext   = cy + 17'(yBin);
        xHit     = !xFound && ({cxNext, 1'b0} >= 18'(xAcc));
        yHit     = !yFound && ({cyNext, 1'b0} >= 18'(yAcc));
        xMedNext = xHit ? k : xMedReg;
        yMedNext = yHit ? k : yMedReg;
    end

    always_ff @(posedge clk) begin
        if (xTake) xBuf[xCnt] <= hif.xHistogramIn;
        if (yTake) yBuf[yCnt] <= hif.yHistogramIn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            holdCnt     <= 1'b0;
            xCnt        <= '0;
            yCnt        <= '0;
            xAcc        <= '0;
            yAcc        <= '0;
            k           <= '0;
            cx          <= '0;
            cy          <= '0;
            xFound      <= 1'b0;
            yFound      <= 1'b0;
            xMedReg     <= '0;
            yMedReg     <= '0;
            hif.done    <= 1'b0;
            hif.xMedian <= '0;
            hif.yMedian <= '0;
            hif.xTotal  <= '0;
            hif.yTotal  <= '0;
            hif.empty   <= 1'b0;
        end else begin
            state    <= stateNext;
            hif.done <= 1'b0;
            case (state)
                IDLE: if (hif.start) begin
                    xCnt <= '0;
                    yCnt <= '0;
                    xAcc <= '0;
                    yAcc <= '0;
                end
                HOLD: holdCnt <= !holdCnt;
                COLLECT: begin
                    if (xTake) begin
                        xCnt <= xCnt + 1'b1;
                        xAcc <= xAcc + 16'(hif.xHistogramIn);
                    end
                    if (yTake) begin
                        yCnt <= yCnt + 1'b1;
                        yAcc <= yAcc + 16'(hif.yHistogramIn);
                    end
                    k      <= '0;
                    cx     <= '0;
                    cy     <= '0;
                    xFound <= 1'b0;
                    yFound <= 1'b0;
                end
                SCAN: begin
                    k  <= k + 1'b1;
                    cx <= cxNext;
                    cy <= cyNext;
                    if (xHit) begin
                        xFound  <= 1'b1;
                        xMedReg <= k;
                    end
                    if (yHit) begin
                        yFound  <= 1'b1;
                        yMedReg <= k;
                    end
                    if (k == LASTK) begin
                        hif.done    <= 1'b1;
                        hif.xTotal  <= xAcc;
                        hif.yTotal  <= yAcc;
                        hif.xMedian <= (xAcc == '0) ? 8'd0 : 8'(xMedNext);
                        hif.yMedian <= (yAcc == '0) ? 8'd0 : 8'(yMedNext);
                        hif.empty   <= (xAcc == '0) || (yAcc == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
